game_sound_sequencer: RTL and testbench

GAME_SOUND_SEQUENCER -- requirements
Module: game_sound_sequencer

---
 rtl/game_sound_sequencer_if.sv | 26 ++
 rtl/game_sound_sequencer.sv | 110 +++++++++++
 tb/tb_game_sound_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/game_sound_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : game_sound_sequencer_if
// Description : Event inputs and beeper-facing status of the sound sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_sound_sequencer_if;
    logic       lose_evt;
    logic       win_evt;
    logic       restart;
    logic [1:0] gameState;
    logic [2:0] count_8_4Hz;
    logic       busy;
    logic       done;

    modport master (
        output lose_evt, win_evt, restart,
        input  gameState, count_8_4Hz, busy, done
    );

    modport slave (
        input  lose_evt, win_evt, restart,
        output gameState, count_8_4Hz, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/game_sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sound_sequencer
// Description : Plays a lose/win pattern of 8 phases at 4 Hz, REPEAT times,
//               then falls silent until restart.
// Revision    : 1.0 - initial release
// ============================================================================
module game_sound_sequencer #(
    parameter int DIV_4HZ = 12500000,
    parameter int REPEAT  = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    game_sound_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_LOSE = 2'd0,
        ST_WIN  = 2'd1,
        ST_PLAY = 2'd2,
        ST_END  = 2'd3
    } state_t;

    localparam logic [23:0] c_PRESC_LAST = 24'(DIV_4HZ - 1);
    localparam logic [3:0]  c_REP_LAST   = 4'(REPEAT - 1);

    state_t      r_state;
    logic [23:0] r_presc;
    logic [2:0]  r_phase;
    logic [3:0]  r_rep;
    logic        r_busy;
    logic        r_done;

    logic w_tick;
    logic w_last;

    assign w_tick = (r_presc == c_PRESC_LAST);
    // Final tick of the final phase of the final repetition.
    assign w_last = w_tick && (r_phase == 3'd7) && (r_rep == c_REP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_PLAY;
            r_presc <= '0;
            r_phase <= '0;
            r_rep   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.restart) begin
                r_state <= ST_PLAY;
                r_presc <= '0;
                r_phase <= '0;
                r_rep   <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_PLAY: begin
                        r_presc <= '0;
                        r_phase <= '0;
                        r_rep   <= '0;
                        if (bus.lose_evt) begin
                            r_state <= ST_LOSE;
                            r_busy  <= 1'b1;
                        end else if (bus.win_evt) begin
                            r_state <= ST_WIN;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_LOSE, ST_WIN: begin
                        if (w_tick) begin
                            r_presc <= '0;
                            if (w_last) begin
                                r_state <= ST_END;
                                r_phase <= '0;
                                r_rep   <= '0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_phase <= r_phase + 3'd1;
                                if (r_phase == 3'd7) begin
                                    r_rep <= r_rep + 4'd1;
                                end
                            end
                        end else begin
                            r_presc <= r_presc + 24'd1;
                        end
                    end
                    ST_END: begin
                        r_presc <= '0;
                        r_phase <= '0;
                        r_rep   <= '0;
                    end
                    default: begin
                        r_state <= ST_PLAY;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.gameState   = r_state;
    assign bus.count_8_4Hz = r_phase;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_game_sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_sound_sequencer
// Description : Random and directed stimulus against a time-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sound_sequencer;

    localparam int DIV   = 4;
    localparam int REP   = 2;
    localparam int TOTAL = 8 * REP * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic chk_en = 1'b0;

    int total = 0;
    int bad   = 0;

    // Model: result mode plus cycles elapsed since the result began.
    int m_mode = 2;
    int m_t    = 0;
    int m_done = 0;

    game_sound_sequencer_if bus ();

    game_sound_sequencer #(
        .DIV_4HZ (DIV),
        .REPEAT  (REP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 2;
            m_t    <= 0;
            m_done <= 0;
        end else begin
            m_done <= 0;
            if (bus.restart) begin
                m_mode <= 2;
                m_t    <= 0;
            end else if (m_mode == 2) begin
                if (bus.lose_evt) begin
                    m_mode <= 0;
                    m_t    <= 0;
                end else if (bus.win_evt) begin
                    m_mode <= 1;
                    m_t    <= 0;
                end
            end else if (m_mode < 2) begin
                if (m_t + 1 == TOTAL) begin
                    m_mode <= 3;
                    m_t    <= 0;
                    m_done <= 1;
                end else begin
                    m_t <= m_t + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_state", int'(bus.gameState), m_mode);
            check("model_phase", int'(bus.count_8_4Hz), (m_mode < 2) ? (m_t / DIV) % 8 : 0);
            check("model_busy", int'(bus.busy), (m_mode < 2) ? 1 : 0);
            check("model_done", int'(bus.done), m_done);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input logic l, input logic w, input logic r);
        step();
        bus.lose_evt = l;
        bus.win_evt  = w;
        bus.restart  = r;
        step();
        bus.lose_evt = 1'b0;
        bus.win_evt  = 1'b0;
        bus.restart  = 1'b0;
    endtask

    initial begin
        bus.lose_evt = 1'b0;
        bus.win_evt  = 1'b0;
        bus.restart  = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        #20;
        check("reset_state", int'(bus.gameState), 2);
        check("reset_phase", int'(bus.count_8_4Hz), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        step();
        rst_n = 1'b1;

        // Win pattern: 2 passes of 8 phases, 4 cycles each.
        pulse(1'b0, 1'b1, 1'b0);
        check("win_entry_state", int'(bus.gameState), 1);
        for (int i = 0; i < TOTAL; i++) begin
            check("win_phase", int'(bus.count_8_4Hz), (i / 4) % 8);
            check("win_done_low", int'(bus.done), 0);
            step();
        end
        check("win_end_state", int'(bus.gameState), 3);
        check("win_end_done", int'(bus.done), 1);
        check("win_end_busy", int'(bus.busy), 0);
        step();
        check("win_done_once", int'(bus.done), 0);

        // Events ignored in END; only restart leaves it.
        pulse(1'b0, 1'b1, 1'b0);
        check("end_ignores_win", int'(bus.gameState), 3);
        repeat (3) step();
        check("end_holds", int'(bus.gameState), 3);
        pulse(1'b0, 1'b0, 1'b1);
        check("end_restart", int'(bus.gameState), 2);

        // Lose has priority; win ignored in LOSE; restart at phase 5.
        pulse(1'b1, 1'b1, 1'b0);
        check("both_state", int'(bus.gameState), 0);
        check("both_busy", int'(bus.busy), 1);
        pulse(1'b0, 1'b1, 1'b0);
        check("lose_ignores_win", int'(bus.gameState), 0);
        repeat (18) step();
        check("lose_phase5", int'(bus.count_8_4Hz), 5);
        pulse(1'b0, 1'b0, 1'b1);
        check("abort_state", int'(bus.gameState), 2);
        check("abort_phase", int'(bus.count_8_4Hz), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);

        // Restart beats lose.
        pulse(1'b1, 1'b0, 1'b1);
        check("restart_lose_state", int'(bus.gameState), 2);
        check("restart_lose_busy", int'(bus.busy), 0);

        // Asynchronous reset mid-pattern at phase 3.
        pulse(1'b0, 1'b1, 1'b0);
        repeat (12) step();
        check("win_phase3", int'(bus.count_8_4Hz), 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_state", int'(bus.gameState), 2);
        check("async_phase", int'(bus.count_8_4Hz), 0);
        check("async_done", int'(bus.done), 0);
        check("async_busy", int'(bus.busy), 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_state", int'(bus.gameState), 2);

        // Random traffic, including occasional asynchronous resets.
        repeat (4000) begin
            step();
            rst_n        = ($urandom_range(0, 999) >= 2);
            bus.lose_evt = ($urandom_range(0, 39) == 0);
            bus.win_evt  = ($urandom_range(0, 39) == 0);
            bus.restart  = ($urandom_range(0, 149) == 0);
        end
        step();
        rst_n        = 1'b1;
        bus.lose_evt = 1'b0;
        bus.win_evt  = 1'b0;
        bus.restart  = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
